// File: rtl/branch_unit.sv
// Execute-stage branch/jump resolution: condition compare, target/link generation,
// misalignment and illegal detection, valid/ready result register and perf counters.
module branch_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned C_EXT = 0,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_misalign,
    output logic             out_illegal,
    output logic             out_redirect,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam logic [1:0] KindBranch = 2'd0;
    localparam logic [1:0] KindJal    = 2'd1;
    localparam logic [1:0] KindJalr   = 2'd2;

    logic            w_accept;
    logic            w_retire;
    logic [XLEN-1:0] w_link;
    logic [XLEN-1:0] w_raw_target;
    logic [XLEN-1:0] w_target;
    logic            w_cond;
    logic            w_taken;
    logic            w_illegal;
    logic            w_misalign;

    logic             r_out_valid;
    logic             r_taken;
    logic [XLEN-1:0]  r_target;
    logic [XLEN-1:0]  r_link;
    logic             r_misalign;
    logic             r_illegal;
    logic             r_is_branch;
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_taken;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;
    // A result discarded by flush in the same cycle it handshakes is not counted.
    assign w_retire = r_out_valid && out_ready && !flush;

    always_comb begin
        w_link       = in_pc + XLEN'(4);
        w_raw_target = in_pc + in_imm;
        w_cond       = 1'b0;
        w_illegal    = 1'b0;
        w_taken      = 1'b0;
        w_misalign   = 1'b0;
        w_target     = w_link;
        case (in_kind)
            KindBranch: begin
                case (in_funct3)
                    3'b000:  w_cond = (in_rs1 == in_rs2);
                    3'b001:  w_cond = (in_rs1 != in_rs2);
                    3'b100:  w_cond = ($signed(in_rs1) < $signed(in_rs2));
                    3'b101:  w_cond = !($signed(in_rs1) < $signed(in_rs2));
                    3'b110:  w_cond = (in_rs1 < in_rs2);
                    3'b111:  w_cond = !(in_rs1 < in_rs2);
                    default: w_illegal = 1'b1;
                endcase
                w_taken = w_cond && !w_illegal;
            end
            KindJal: w_taken = 1'b1;
            KindJalr: begin
                w_taken      = 1'b1;
                w_raw_target = (in_rs1 + in_imm) & ~XLEN'(1);
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_taken) begin
            w_target   = w_raw_target;
            w_misalign = (C_EXT != 0) ? w_raw_target[0] : (w_raw_target[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
            r_link      <= '0;
            r_misalign  <= 1'b0;
            r_illegal   <= 1'b0;
            r_is_branch <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_taken     <= w_taken;
            r_target    <= w_target;
            r_link      <= w_link;
            r_misalign  <= w_misalign;
            r_illegal   <= w_illegal;
            r_is_branch <= (in_kind == KindBranch);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_branch <= '0;
            r_cnt_taken  <= '0;
        end else if (cnt_clr) begin
            r_cnt_branch <= '0;
            r_cnt_taken  <= '0;
        end else if (w_retire && r_is_branch && !r_illegal) begin
            if (r_cnt_branch != '1) r_cnt_branch <= r_cnt_branch + CNT_W'(1);
            if (r_taken && (r_cnt_taken != '1)) r_cnt_taken <= r_cnt_taken + CNT_W'(1);
        end
    end

    assign out_valid    = r_out_valid;
    assign out_taken    = r_taken;
    assign out_target   = r_target;
    assign out_link     = r_link;
    assign out_misalign = r_misalign;
    assign out_illegal  = r_illegal;
    assign out_redirect = r_taken && !r_misalign && !r_illegal;
    assign cnt_branch   = r_cnt_branch;
    assign cnt_taken    = r_cnt_taken;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: instance a is 4-byte aligned with 2-bit counters,
// instance b has 2-byte alignment; both see the same stimulus.
module tb_branch_unit;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, out_ready, flush, cnt_clr;
    logic [1:0]      in_kind;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_pc, in_rs1, in_rs2, in_imm;

    logic            a_in_ready, a_valid, a_taken, a_mis, a_ill, a_redir;
    logic [XLEN-1:0] a_target, a_link;
    logic [1:0]      a_cnt_br, a_cnt_tk;
    logic            b_in_ready, b_valid, b_taken, b_mis, b_ill, b_redir;
    logic [XLEN-1:0] b_target, b_link;
    logic [31:0]     b_cnt_br, b_cnt_tk;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(XLEN), .C_EXT(0), .CNT_W(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .flush(flush), .out_valid(a_valid),
        .out_ready(out_ready), .out_taken(a_taken), .out_target(a_target),
        .out_link(a_link), .out_misalign(a_mis), .out_illegal(a_ill),
        .out_redirect(a_redir), .cnt_clr(cnt_clr), .cnt_branch(a_cnt_br),
        .cnt_taken(a_cnt_tk)
    );

    branch_unit #(.XLEN(XLEN), .C_EXT(1), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .flush(flush), .out_valid(b_valid),
        .out_ready(out_ready), .out_taken(b_taken), .out_target(b_target),
        .out_link(b_link), .out_misalign(b_mis), .out_illegal(b_ill),
        .out_redirect(b_redir), .cnt_clr(cnt_clr), .cnt_branch(b_cnt_br),
        .cnt_taken(b_cnt_tk)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] f3, input logic [63:0] pc,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
        in_kind   = k;
        in_funct3 = f3;
        in_pc     = pc;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    // Presents one request for a single cycle; result is visible on return.
    task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [63:0] pc,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
        @(negedge clk);
        drive(k, f3, pc, rs1, rs2, imm);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear_counters();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic tk, input logic [63:0] tgt,
                                input logic [63:0] lnk, input logic mis, input logic ill,
                                input logic rd);
        check_eq({tag, ".valid"}, 64'(a_valid), 64'd1);
        check_eq({tag, ".taken"}, 64'(a_taken), 64'(tk));
        check_eq({tag, ".target"}, a_target, tgt);
        check_eq({tag, ".link"}, a_link, lnk);
        check_eq({tag, ".misalign"}, 64'(a_mis), 64'(mis));
        check_eq({tag, ".illegal"}, 64'(a_ill), 64'(ill));
        check_eq({tag, ".redirect"}, 64'(a_redir), 64'(rd));
    endtask

    task automatic check_counters(input string tag, input logic [1:0] br, input logic [1:0] tk);
        check_eq({tag, ".cnt_branch"}, 64'(a_cnt_br), 64'(br));
        check_eq({tag, ".cnt_taken"}, 64'(a_cnt_tk), 64'(tk));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        drive(2'd0, 3'd0, '0, '0, '0, '0);
        #1;
        check_eq("rst.valid", 64'(a_valid), 64'd0);
        check_eq("rst.target", a_target, 64'd0);
        check_eq("rst.in_ready", 64'(a_in_ready), 64'd1);
        check_counters("rst", 2'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(2'd0, 3'b000, 64'h1000, 64'd5, 64'd5, 64'h20);
        check_result("beq", 1'b1, 64'h1020, 64'h1004, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("beq.retired_valid", 64'(a_valid), 64'd0);
        check_counters("beq", 2'd1, 2'd1);

        issue(2'd0, 3'b100, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40);
        check_result("blt", 1'b1, 64'h3040, 64'h3004, 1'b0, 1'b0, 1'b1);
        issue(2'd0, 3'b110, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40);
        check_result("bltu", 1'b0, 64'h3004, 64'h3004, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_counters("blt_bltu", 2'd3, 2'd2);

        clear_counters();
        check_counters("clr1", 2'd0, 2'd0);

        issue(2'd2, 3'b000, 64'h500, 64'h2003, 64'd0, 64'd0);
        check_result("jalr", 1'b1, 64'h2002, 64'h504, 1'b1, 1'b0, 1'b0);
        check_eq("jalr_c.misalign", 64'(b_mis), 64'd0);
        check_eq("jalr_c.redirect", 64'(b_redir), 64'd1);
        check_eq("jalr_c.target", b_target, 64'h2002);

        issue(2'd1, 3'b000, 64'h100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8);
        check_result("jal", 1'b1, 64'hF8, 64'h104, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_counters("jumps_not_counted", 2'd0, 2'd0);

        // Hold: first result stalls while a second request waits.
        out_ready = 1'b0;
        drive(2'd0, 3'b101, 64'h4000, 64'd5, 64'd5, 64'h10);
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("hold.valid", 64'(a_valid), 64'd1);
        drive(2'd0, 3'b001, 64'h5000, 64'd9, 64'd9, 64'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("hold.stable_target", a_target, 64'h4010);
            check_eq("hold.stable_taken", 64'(a_taken), 64'd1);
            check_eq("hold.in_ready", 64'(a_in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_result("hold.second", 1'b0, 64'h5004, 64'h5004, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("hold.drained", 64'(a_valid), 64'd0);
        check_counters("hold", 2'd2, 2'd1);

        // Flush with a held result and a same-cycle request.
        out_ready = 1'b0;
        drive(2'd0, 3'b000, 64'h6000, 64'd1, 64'd1, 64'h8);
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("flush.pre_valid", 64'(a_valid), 64'd1);
        drive(2'd1, 3'b000, 64'h6100, 64'd0, 64'd0, 64'h8);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush.valid", 64'(a_valid), 64'd0);
        @(negedge clk);
        check_eq("flush.dropped", 64'(a_valid), 64'd0);
        check_counters("flush", 2'd2, 2'd1);

        issue(2'd0, 3'b010, 64'h7000, 64'd3, 64'd3, 64'h40);
        check_result("ill_f3", 1'b0, 64'h7004, 64'h7004, 1'b0, 1'b1, 1'b0);
        issue(2'd3, 3'b000, 64'h8000, 64'd3, 64'd3, 64'h40);
        check_result("ill_kind", 1'b0, 64'h8004, 64'h8004, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_counters("illegal", 2'd2, 2'd1);

        clear_counters();
        for (int i = 0; i < 5; i++) issue(2'd0, 3'b000, 64'h9000, 64'd7, 64'd7, 64'h4);
        @(negedge clk);
        check_counters("saturate", 2'd3, 2'd3);
        clear_counters();
        check_counters("clr2", 2'd0, 2'd0);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        drive(2'd1, 3'b000, 64'hA000, 64'd0, 64'd0, 64'h10);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("areset.pre_valid", 64'(a_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("areset.valid", 64'(a_valid), 64'd0);
        check_eq("areset.target", a_target, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
